systolic_skew_feeder: RTL

Transmit-side front end for the NDP systolic array. It accepts one unskewed A column-slice and one B row-slice per handshake and drives the array's west (in_a) and north (in_b) edges.
- Each edge is diagonally skewed: row i is delayed i cycles and column j is delayed j cycles.
- After the last operand it inserts zero bubbles until the final product has reached PE(H-1,W-1).
- It then pulses the done flag that drives the array's in_done_flag.

---
 rtl/systolic_skew_feeder_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 31 +++
 rtl/systolic_skew_feeder.sv | 107 ++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFeed,
    StFlush,
    StDone
  } state_e;

  // Zero-bubble cycles needed after the last operand to reach PE(H-1,W-1) and accumulate.
  function automatic int unsigned flush_len(input int unsigned h, input int unsigned w,
                                            input int unsigned pe_lat);
    return h + w - 2 + pe_lat;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Free-running per-lane delay line used to diagonally skew one array edge lane.
module skew_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused;
    assign w_unused = clk ^ reset;
    assign out_data = in_data;
  end else begin : g_shift
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < DEPTH; k++) r_stage[k] <= '0;
      end else begin
        r_stage[0] <= in_data;
        for (int k = 1; k < DEPTH; k++) r_stage[k] <= r_stage[k-1];
      end
    end

    assign out_data = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds skewed A/B operand slices into the systolic array edges and flags job completion.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ARR_HEIGHT = 4,
  parameter int unsigned ARR_WIDTH  = 4,
  parameter int unsigned PE_LAT     = 2,
  parameter int unsigned K_BITS     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_BITS-1:0]           k_len,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0] in_a_vec,
  input  logic [ARR_WIDTH*WIDTH-1:0]  in_b_vec,
  output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
  output logic                        out_done_flag,
  output logic                        busy
);

  localparam int unsigned FlushLen = flush_len(ARR_HEIGHT, ARR_WIDTH, PE_LAT);
  localparam int unsigned FBits    = $clog2(FlushLen + 1);

  state_e                      r_state;
  state_e                      w_state_d;
  logic [K_BITS-1:0]           r_remaining;
  logic [FBits-1:0]            r_flush_cnt;
  logic                        w_accept;
  logic [ARR_HEIGHT*WIDTH-1:0] r_head_a;
  logic [ARR_WIDTH*WIDTH-1:0]  r_head_b;

  assign w_accept = (r_state == StFeed) & in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = (k_len == '0) ? StDone : StFeed;
      StFeed:  if (w_accept && r_remaining == K_BITS'(1)) w_state_d = StFlush;
      StFlush: if (r_flush_cnt == FBits'(1)) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready      = (r_state == StFeed);
    busy          = (r_state != StIdle);
    out_done_flag = (r_state == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remaining <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state == StIdle && start) r_remaining <= k_len;
      else if (w_accept)              r_remaining <= r_remaining - K_BITS'(1);
      if (r_state == StFeed && w_state_d == StFlush) r_flush_cnt <= FBits'(FlushLen);
      else if (r_state == StFlush)                   r_flush_cnt <= r_flush_cnt - FBits'(1);
    end
  end

  // Lane heads load zeros on non-accept cycles so the free-running array sees bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head_a <= '0;
      r_head_b <= '0;
    end else begin
      r_head_a <= w_accept ? in_a_vec : '0;
      r_head_b <= w_accept ? in_b_vec : '0;
    end
  end

  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a_lane
    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(i)
    ) u_dly (
      .clk     (clk),
      .reset   (reset),
      .in_data (r_head_a[i*WIDTH +: WIDTH]),
      .out_data(out_a[i*WIDTH +: WIDTH])
    );
  end

  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b_lane
    skew_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(j)
    ) u_dly (
      .clk     (clk),
      .reset   (reset),
      .in_data (r_head_b[j*WIDTH +: WIDTH]),
      .out_data(out_b[j*WIDTH +: WIDTH])
    );
  end

endmodule
